// File: rtl/itree_loader.sv
// Byte-serial isolation-tree configuration loader: assembles a checksummed frame
// into a shadow register and hands it to the detector until the load is confirmed.
module itree_loader #(
    parameter int unsigned TREE_BYTES = 32,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              cfg_data,
    input  logic                    cfg_valid,
    input  logic                    cfg_last,
    output logic                    cfg_ready,
    input  logic                    data_valid_mon,
    output logic [8*TREE_BYTES-1:0] itree_out,
    output logic                    load_itree,
    output logic                    frame_err,
    output logic [ERR_CNT_W-1:0]    err_count,
    output logic [7:0]              frames_ok
);

    localparam int unsigned TREE_W = 8 * TREE_BYTES;
    localparam int unsigned CNT_W  = $clog2(TREE_BYTES + 1);

    typedef enum logic [1:0] {
        COLLECT,
        DRAIN,
        CHECK,
        PRESENT
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   byte_cnt;
    logic [7:0]         chk;
    logic [7:0]         cks;
    logic [TREE_W-1:0]  shadow;
    logic               xfer;
    logic               tree_phase;
    logic               reject_c;

    assign cfg_ready = (state == COLLECT) || (state == DRAIN);

    // Every rejection cause funnels through one flag so the cleanup is shared.
    always_comb begin
        xfer       = cfg_valid && cfg_ready;
        tree_phase = (byte_cnt < CNT_W'(TREE_BYTES));
        reject_c   = 1'b0;
        case (state)
            COLLECT: reject_c = xfer && cfg_last && tree_phase;
            DRAIN:   reject_c = xfer && cfg_last;
            CHECK:   reject_c = (chk != cks);
            default: reject_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= COLLECT;
            byte_cnt   <= '0;
            chk        <= '0;
            cks        <= '0;
            shadow     <= '0;
            itree_out  <= '0;
            load_itree <= 1'b0;
            frame_err  <= 1'b0;
            err_count  <= '0;
            frames_ok  <= '0;
        end else begin
            frame_err <= reject_c;
            if (reject_c) begin
                state    <= COLLECT;
                byte_cnt <= '0;
                chk      <= '0;
                if (err_count != '1) begin
                    err_count <= err_count + 1'b1;
                end
            end else begin
                case (state)
                    COLLECT: begin
                        if (xfer) begin
                            if (tree_phase) begin
                                shadow[8*byte_cnt +: 8] <= cfg_data;
                                chk                     <= chk ^ cfg_data;
                                byte_cnt                <= byte_cnt + 1'b1;
                            end else if (cfg_last) begin
                                cks   <= cfg_data;
                                state <= CHECK;
                            end else begin
                                state <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        state <= DRAIN;
                    end
                    CHECK: begin
                        itree_out  <= shadow;
                        load_itree <= 1'b1;
                        frames_ok  <= frames_ok + 8'd1;
                        byte_cnt   <= '0;
                        chk        <= '0;
                        state      <= PRESENT;
                    end
                    PRESENT: begin
                        // Detector samples the tree only on a data_valid cycle.
                        if (data_valid_mon) begin
                            load_itree <= 1'b0;
                            state      <= COLLECT;
                        end
                    end
                    default: state <= COLLECT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_itree_loader.sv
// Directed bench for itree_loader: table of whole-frame cases plus hand-built
// sequences for backpressure, async reset, counter saturation and wrap.
module tb_itree_loader;

    logic         clk;
    logic         reset;
    logic [7:0]   cfg_data;
    logic         cfg_valid;
    logic         cfg_last;
    logic         cfg_ready;
    logic         data_valid_mon;
    logic [255:0] itree_out;
    logic         load_itree;
    logic         frame_err;
    logic [7:0]   err_count;
    logic [7:0]   frames_ok;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int ready_viol = 0;
    int stalls = 0;

    itree_loader #(.TREE_BYTES(32), .ERR_CNT_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_data       (cfg_data),
        .cfg_valid      (cfg_valid),
        .cfg_last       (cfg_last),
        .cfg_ready      (cfg_ready),
        .data_valid_mon (data_valid_mon),
        .itree_out      (itree_out),
        .load_itree     (load_itree),
        .frame_err      (frame_err),
        .err_count      (err_count),
        .frames_ok      (frames_ok)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (reset && frame_err) err_pulses++;
        if (reset && load_itree && cfg_ready) ready_viol++;
    end

    typedef struct {
        logic [7:0] seed;
        int         len;
        logic [7:0] flip;
        bit         gaps;
        bit         dvm_in_check;
        bit         exp_load;
        int         exp_pulses;
        logic [7:0] exp_err;
        logic [7:0] exp_fok;
        logic [7:0] exp_seed;
    } vec_t;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] exp_tree(input logic [7:0] seed);
        logic [255:0] t;
        t = '0;
        for (int k = 0; k < 32; k++) t[8*k +: 8] = 8'(seed + 8'(k));
        return t;
    endfunction

    task automatic idle_inputs();
        cfg_valid = 1'b0;
        cfg_data  = 8'hFF;
        cfg_last  = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_last  = l;
        while (!cfg_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
            stalls++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic send_stream(input logic [7:0] seed, input int len, input logic [7:0] flip,
                               input bit gaps);
        logic [7:0] x;
        logic [7:0] d;
        x = 8'h00;
        for (int k = 0; k < len; k++) begin
            if (k == 32) d = x ^ flip;
            else         d = 8'(seed + 8'(k));
            if (k < 32) x = x ^ d;
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_byte(d, (k == len - 1));
        end
    endtask

    // Called 1ns after the edge that took the final byte.
    task automatic post_frame(input bit exp_load, input int hold, input bit dvm_in_check);
        check("lat_check_cycle", 256'(load_itree), 256'(0));
        if (dvm_in_check) data_valid_mon = 1'b1;
        @(posedge clk); #1;
        data_valid_mon = 1'b0;
        check("lat_load", 256'(load_itree), 256'(exp_load));
        if (exp_load) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check("load_hold", 256'(load_itree), 256'(1));
            end
            data_valid_mon = 1'b1;
            @(posedge clk); #1;
            data_valid_mon = 1'b0;
            check("load_confirm", 256'(load_itree), 256'(0));
        end
    endtask

    vec_t vecs[6];
    logic [7:0] fok_exp;

    initial begin
        vecs[0] = '{8'h01, 33, 8'h00, 1'b0, 1'b0, 1'b1, 0, 8'd0, 8'd1, 8'h01};
        vecs[1] = '{8'h01, 33, 8'h01, 1'b0, 1'b0, 1'b0, 1, 8'd1, 8'd1, 8'h01};
        vecs[2] = '{8'h40, 11, 8'h00, 1'b0, 1'b0, 1'b0, 1, 8'd2, 8'd1, 8'h01};
        vecs[3] = '{8'h10, 33, 8'h00, 1'b1, 1'b0, 1'b1, 0, 8'd2, 8'd2, 8'h10};
        vecs[4] = '{8'h55, 40, 8'h00, 1'b0, 1'b0, 1'b0, 1, 8'd3, 8'd2, 8'h10};
        vecs[5] = '{8'hA0, 33, 8'h00, 1'b1, 1'b1, 1'b1, 0, 8'd3, 8'd3, 8'hA0};

        reset = 1'b0;
        data_valid_mon = 1'b0;
        idle_inputs();
        #12;
        check("rst_ready", 256'(cfg_ready), 256'(1));
        check("rst_load", 256'(load_itree), 256'(0));
        check("rst_itree", itree_out, 256'(0));
        check("rst_err", 256'(err_count), 256'(0));
        check("rst_fok", 256'(frames_ok), 256'(0));
        check("rst_ferr", 256'(frame_err), 256'(0));
        #10 reset = 1'b1;
        @(posedge clk); #1;
        check("first_byte0", itree_out[7:0], 256'(0));

        for (int v = 0; v < 6; v++) begin
            int p0;
            p0 = err_pulses;
            stalls = 0;
            send_stream(vecs[v].seed, vecs[v].len, vecs[v].flip, vecs[v].gaps);
            post_frame(vecs[v].exp_load, 5, vecs[v].dvm_in_check);
            repeat (2) begin @(posedge clk); #1; end
            check("vec_pulses", 256'(err_pulses - p0), 256'(vecs[v].exp_pulses));
            check("vec_err_count", 256'(err_count), 256'(vecs[v].exp_err));
            check("vec_frames_ok", 256'(frames_ok), 256'(vecs[v].exp_fok));
            check("vec_itree", itree_out, exp_tree(vecs[v].exp_seed));
            check("vec_no_stall", 256'(stalls), 256'(0));
        end
        check("spec_byte_lo", 256'(8'h01), exp_tree(8'h01) & 256'hFF);
        check("spec_byte_hi", 256'(8'h20), exp_tree(8'h01) >> 248);

        // Second frame offered while the first is still being presented.
        send_stream(8'h30, 33, 8'h00, 1'b0);
        post_frame(1'b1, 0, 1'b0);
        data_valid_mon = 1'b0;
        send_stream(8'h30, 33, 8'h00, 1'b0);
        check("bp_lat", 256'(load_itree), 256'(0));
        @(posedge clk); #1;
        check("bp_load1", 256'(load_itree), 256'(1));
        stalls = 0;
        fork
            send_stream(8'h60, 33, 8'h00, 1'b1);
            begin
                for (int i = 0; i < 6; i++) begin
                    check("bp_ready_low", 256'(cfg_ready), 256'(0));
                    @(posedge clk); #1;
                end
                data_valid_mon = 1'b1;
                @(posedge clk); #1;
                data_valid_mon = 1'b0;
            end
        join
        check("bp_stalled", 256'(stalls > 0), 256'(1));
        post_frame(1'b1, 2, 1'b0);
        check("bp_itree", itree_out, exp_tree(8'h60));
        check("bp_fok", 256'(frames_ok), 256'(6));

        // Asynchronous reset mid-frame.
        for (int k = 0; k < 16; k++) send_byte(8'(8'h70 + 8'(k)), 1'b0);
        #2 reset = 1'b0;
        #1;
        check("arst_itree", itree_out, 256'(0));
        check("arst_err", 256'(err_count), 256'(0));
        check("arst_fok", 256'(frames_ok), 256'(0));
        check("arst_ready", 256'(cfg_ready), 256'(1));
        #2 reset = 1'b1;
        @(posedge clk); #1;
        send_stream(8'h01, 33, 8'h00, 1'b0);
        post_frame(1'b1, 1, 1'b0);
        check("arst_reload", itree_out, exp_tree(8'h01));
        check("arst_fok1", 256'(frames_ok), 256'(1));

        // Asynchronous reset during PRESENT.
        send_stream(8'h22, 33, 8'h00, 1'b0);
        @(posedge clk); #1;
        check("pres_load", 256'(load_itree), 256'(1));
        #2 reset = 1'b0;
        #1;
        check("prst_load", 256'(load_itree), 256'(0));
        check("prst_itree", itree_out, 256'(0));
        check("prst_fok", 256'(frames_ok), 256'(0));
        #2 reset = 1'b1;
        @(posedge clk); #1;
        send_stream(8'hC3, 33, 8'h00, 1'b0);
        post_frame(1'b1, 1, 1'b0);
        check("prst_reload", itree_out, exp_tree(8'hC3));

        // err_count saturates at all-ones.
        for (int i = 0; i < 256; i++) send_stream(8'h00, 1, 8'h00, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        check("err_sat", 256'(err_count), 256'(255));

        // frames_ok wraps: 256 accepted frames return it to its start value.
        fok_exp = frames_ok;
        for (int i = 0; i < 256; i++) begin
            send_stream(8'(i), 33, 8'h00, 1'b0);
            post_frame(1'b1, 0, 1'b0);
            if (i == 254) check("fok_255", 256'(frames_ok), 256'(8'(fok_exp + 8'd255)));
        end
        check("fok_wrap", 256'(frames_ok), 256'(fok_exp));
        check("wrap_itree", itree_out, exp_tree(8'hFF));
        check("present_ready_low", 256'(ready_viol), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
